serial_op_control: RTL
======================

// Module: serial_op_control
// PURPOSE
//  Control unit for the 8-bit bit-serial logic processor. It sits between the
//  button debouncers (upstream) and the register/compute/router datapath
//  (downstream). It turns debounced LoadA/LoadB/Execute levels into register
//  load strobes and exactly WIDTH shift-enable cycles per Execute press.
//  Each press runs one operation, however long Execute stays high.
// PARAMETERS
//  WIDTH    8                  operand width = number of shift cycles per operation
//  COUNT_W  $clog2(WIDTH)      width of Bit_Count
// PORTS
//  Clk        in   1        system clock; all state changes on posedge
//  Reset      in   1        synchronous, active-high reset
//  LoadA      in   1        debounced level: load A from Din
//  LoadB      in   1        debounced level: load B from Din
//  Execute    in   1        debounced level: start one serial operation
//  Ld_A       out  1        load strobe to register A
//  Ld_B       out  1        load strobe to register B
//  Shift_En   out  1        shift both registers one bit; compute/route this bit
//  Bit_Count  out  COUNT_W  index of the current shift bit: 0..WIDTH-1 in SHIFT, else 0
//  Busy       out  1        high in any state other than IDLE
//  Done       out  1        one-cycle pulse after the last shift
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-high.
//    * On a Reset edge: state=IDLE, count=0.
//    * While Reset=1, all outputs are 0. This includes Ld_A/Ld_B.
//  - States live in processor_pkg::ctrl_state_t: IDLE, SHIFT, DONE, HOLD.
//  - IDLE:
//    * Execute=1 -> SHIFT, count=0.
//    * Otherwise stay in IDLE.
//  - SHIFT:
//    * Shift_En=1. count increments every cycle.
//    * When count==WIDTH-1: go to DONE, count=0.
//    * Shift_En is therefore high for exactly WIDTH consecutive cycles.
//    * The first shift cycle is the cycle after Execute is first sampled high in IDLE.
//  - DONE:
//    * Done=1 for exactly one cycle.
//    * Execute=1 -> HOLD. Execute=0 -> IDLE.
//  - HOLD:
//    * Wait until Execute=0, then go to IDLE.
//    * A held button never starts a second operation. It must be released and re-asserted.
//  - Output timing:
//    * Shift_En, Busy, Done and Bit_Count decode from registered state/count (Moore).
//    * Ld_A = LoadA & (state==IDLE) & ~Execute & ~Reset. Zero latency, combinational.
//    * Ld_B follows the same rule with LoadB.
//  - Priority and simultaneous events:
//    * Execute beats loads in IDLE. In a cycle where Execute=1, Ld_A and Ld_B are 0.
//    * LoadA and LoadB together in IDLE assert Ld_A and Ld_B together.
//    * LoadA/LoadB are ignored in SHIFT, DONE and HOLD. No load is queued.
//  - Execute falling mid-SHIFT has no effect. The operation always completes all WIDTH shifts.
//  - Reset mid-operation:
//    * Next state is IDLE. Shift_En drops from the next cycle.
//    * Partial register contents are left as they are. This block does not clear the datapath.
//  - Bit_Count never reaches WIDTH. There is no wrap past WIDTH-1.
// STRUCTURE
//  - processor_pkg holds:
//    * ctrl_state_t (enum logic [1:0])
//    * localparam PROC_WIDTH = 8
//  - One natural sub-module: mod_counter (parameterised WIDTH).
//    * Ports: clear, enable, count, terminal (count==WIDTH-1).
//  - The FSM next-state and output decode stay inline.
// TESTING
//  1. Reset=1 for 3 cycles with LoadA=Execute=1
//     -> all outputs 0, Bit_Count=0; state IDLE after release.
//  2. IDLE, LoadA=1 for 4 cycles, LoadB=0
//     -> Ld_A=1 in exactly those 4 cycles; Ld_B=0; Shift_En=0.
//  3. Execute held 22 cycles
//     -> Shift_En=1 for exactly 8 cycles starting 1 cycle after Execute; Bit_Count 0..7.
//     -> Done pulses once, then HOLD (Busy=1) until Execute drops, then IDLE. No second operation.
//  4. Execute 4-cycle pulse
//     -> still 8 Shift_En cycles, then Done, then IDLE directly (no HOLD).
//     -> Re-press after 11 idle cycles starts a fresh 8-shift operation.
//  5. LoadB=1 during SHIFT at Bit_Count=2; LoadA=Execute=1 in the same IDLE cycle
//     -> Ld_B=0 throughout SHIFT; Ld_A=0 and SHIFT entered.
//  6. Reset pulsed at Bit_Count=3
//     -> Shift_En=0 and Busy=0 the next cycle.
//     -> A following Execute yields a full 8 shifts.
//     -> Integrated with datapath: A=33, B=55, F=010, R=10 -> A=66, B=55.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared types and constants for the 8-bit bit-serial logic processor.
// Holds the control FSM state encoding and the default operand width.
package processor_pkg;

    localparam int PROC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } ctrl_state_t;

    // Every state except IDLE counts as an operation in flight.
    function automatic logic state_is_busy(input ctrl_state_t st);
        return (st != IDLE);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-WIDTH bit counter for the serial control unit.
// Synchronous clear takes priority over enable; terminal flags the last index.
module mod_counter #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               Clk,
    input  logic               clear,
    input  logic               enable,
    output logic [COUNT_W-1:0] count,
    output logic               terminal
);

    logic [COUNT_W-1:0] count_r;

    // Count register: clear wins over enable, otherwise hold.
    always_ff @(posedge Clk) begin
        if (clear) begin
            count_r <= {COUNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + COUNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign terminal = (count_r == COUNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_op_control_checker.sv
// Invariant checks for serial_op_control outputs.
// Purely observational; contributes no logic to the datapath.
module serial_op_control_checker #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input logic               Clk,
    input logic               Reset,
    input logic               Execute,
    input logic               Ld_A,
    input logic               Ld_B,
    input logic               Shift_En,
    input logic [COUNT_W-1:0] Bit_Count,
    input logic               Busy,
    input logic               Done
);

    a_shift_busy: assert property (@(posedge Clk) disable iff (Reset)
        Shift_En |-> Busy);

    a_done_not_shift: assert property (@(posedge Clk) disable iff (Reset)
        Done |-> (Busy && !Shift_En));

    a_done_single: assert property (@(posedge Clk) disable iff (Reset)
        Done |=> !Done);

    a_load_idle: assert property (@(posedge Clk) disable iff (Reset)
        (Ld_A || Ld_B) |-> (!Busy && !Execute));

    a_count_range: assert property (@(posedge Clk) disable iff (Reset)
        Bit_Count <= COUNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_op_control.sv
// Control unit of the bit-serial logic processor: turns debounced button levels
// into register load strobes and exactly WIDTH shift-enable cycles per Execute press.
module serial_op_control
    import processor_pkg::*;
#(
    parameter int WIDTH   = PROC_WIDTH,
    parameter int COUNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               LoadA,
    input  logic               LoadB,
    input  logic               Execute,
    output logic               Ld_A,
    output logic               Ld_B,
    output logic               Shift_En,
    output logic [COUNT_W-1:0] Bit_Count,
    output logic               Busy,
    output logic               Done
);

    ctrl_state_t        state_r;
    ctrl_state_t        state_next_s;
    logic [COUNT_W-1:0] count_s;
    logic               terminal_s;
    logic               in_shift_s;
    logic               cnt_clear_s;
    logic               shift_en_s;
    logic               done_s;
    logic               run_s;

    assign in_shift_s  = (state_r == SHIFT);
    assign cnt_clear_s = Reset | ~in_shift_s | terminal_s;

    mod_counter #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) u_counter (
        .Clk      (Clk),
        .clear    (cnt_clear_s),
        .enable   (in_shift_s),
        .count    (count_s),
        .terminal (terminal_s)
    );

    // State register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_next_s = state_r;
        shift_en_s   = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (Execute) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                shift_en_s = 1'b1;
                if (terminal_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                done_s = 1'b1;
                if (Execute) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HOLD: begin
                if (Execute) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Reset forces every output low, even while the state register still holds SHIFT.
    assign run_s     = ~Reset;
    assign Shift_En  = shift_en_s & run_s;
    assign Done      = done_s & run_s;
    assign Busy      = state_is_busy(state_r) & run_s;
    assign Bit_Count = (shift_en_s & run_s) ? count_s : {COUNT_W{1'b0}};

    // Loads are only honoured in IDLE, and Execute takes precedence over them.
    assign Ld_A = LoadA & (state_r == IDLE) & ~Execute & run_s;
    assign Ld_B = LoadB & (state_r == IDLE) & ~Execute & run_s;

    serial_op_control_checker #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) u_checker (
        .Clk       (Clk),
        .Reset     (Reset),
        .Execute   (Execute),
        .Ld_A      (Ld_A),
        .Ld_B      (Ld_B),
        .Shift_En  (Shift_En),
        .Bit_Count (Bit_Count),
        .Busy      (Busy),
        .Done      (Done)
    );

endmodule
